dmem_arbiter: RTL and testbench

Shares the single data-memory port among `NUM_HARTS` single-cycle harts in the multi-core build, using round-robin arbitration. Each hart presents its load/store request on a valid/ready port and gets back a one-cycle registered response. The arbiter sits between the harts' `o_dmem_*` buses and the shared dmem macro. It drives the memory port combinationally from the winner and captures read data on the grant edge.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_rr_picker.sv | 31 +++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the round-robin data-memory arbiter.
// Holds the FSM encoding, default hart count and address alignment mask.
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int NUM_HARTS_DEF = 3;

  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // Index after idx, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational rotating priority encoder for the dmem arbiter.
// Searches from i_ptr upward, wrapping, for the first set request.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = IDX_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one dmem port among NUM_HARTS harts.
// Define DMEM_ARB_LOCK_EN to add i_req_lock for atomic RMW sequences.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_HARTS = NUM_HARTS_DEF,
  parameter int IDX_W     = $clog2(NUM_HARTS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_HARTS-1:0]   i_req_valid,
  output logic [NUM_HARTS-1:0]   o_req_ready,
  input  logic [NUM_HARTS*32-1:0] i_req_addr,
  input  logic [NUM_HARTS-1:0]   i_req_ren,
  input  logic [NUM_HARTS-1:0]   i_req_wen,
  input  logic [NUM_HARTS*32-1:0] i_req_wdata,
  input  logic [NUM_HARTS*4-1:0] i_req_mask,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_HARTS-1:0]   i_req_lock,
`endif
  output logic [NUM_HARTS-1:0]   o_rsp_valid,
  output logic [31:0]            o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic [31:0]            o_mem_addr,
  output logic                   o_mem_ren,
  output logic                   o_mem_wen,
  output logic [31:0]            o_mem_wdata,
  output logic [3:0]             o_mem_mask,
  input  logic [31:0]            i_mem_rdata
);

  arb_state_e             r_state;
  logic [IDX_W-1:0]       r_ptr;
  logic [NUM_HARTS-1:0]   r_rsp_valid;
  logic [31:0]            r_rsp_rdata;
  logic                   r_rsp_err;
`ifdef DMEM_ARB_LOCK_EN
  logic [IDX_W-1:0]       r_owner;
`endif

  logic [NUM_HARTS-1:0]   w_req;
  logic [NUM_HARTS-1:0]   w_gnt;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_pick;
  logic                   w_any;
  logic [31:0]            w_addr;
  logic [31:0]            w_wdata;
  logic [3:0]             w_mask;
  logic                   w_ren;
  logic                   w_wen;
  logic                   w_ill;
  logic [IDX_W-1:0]       w_nxt;

  always_comb begin
    w_req = i_req_valid;
`ifdef DMEM_ARB_LOCK_EN
    if (r_state == LOCKED) begin
      w_req          = '0;
      w_req[r_owner] = i_req_valid[r_owner];
    end
`endif
  end

  rr_picker #(
    .N     (NUM_HARTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_pick)
  );

  // Reset blocks every grant so nothing reaches memory while it is held.
  assign w_any = w_pick & ~i_rst;

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_mask  = '0;
    w_ren   = 1'b0;
    w_wen   = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (w_gnt[h]) begin
        w_addr  = i_req_addr[h*32 +: 32];
        w_wdata = i_req_wdata[h*32 +: 32];
        w_mask  = i_req_mask[h*4 +: 4];
        w_ren   = i_req_ren[h];
        w_wen   = i_req_wen[h];
      end
    end
  end

  assign w_ill = (w_ren & w_wen) | ((w_mask == 4'h0) & (w_ren | w_wen));
  assign w_nxt = IDX_W'(rr_next(int'(w_idx), NUM_HARTS));

  assign o_req_ready = w_any ? w_gnt : '0;
  assign o_mem_addr  = w_any ? (w_addr & ADDR_ALIGN_MASK) : 32'h0;
  assign o_mem_wdata = w_any ? w_wdata : 32'h0;
  assign o_mem_mask  = w_any ? w_mask : 4'h0;
  assign o_mem_ren   = w_any & w_ren & ~w_ill;
  assign o_mem_wen   = w_any & w_wen & ~w_ill;

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ARB;
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      r_owner     <= '0;
`endif
    end else begin
      if (w_any) begin
        r_rsp_valid <= w_gnt;
        r_rsp_rdata <= w_ren ? i_mem_rdata : 32'h0;
        r_rsp_err   <= w_ill;
        if (r_state == ARB)
          r_ptr <= w_nxt;
      end else begin
        r_rsp_valid <= '0;
        r_rsp_err   <= 1'b0;
      end
`ifdef DMEM_ARB_LOCK_EN
      unique case (r_state)
        ARB: begin
          if (w_any && i_req_lock[w_idx]) begin
            r_state <= LOCKED;
            r_owner <= w_idx;
          end
        end
        LOCKED: begin
          if (!i_req_lock[r_owner] &&
              (w_any || !i_req_valid[r_owner])) begin
            r_state <= ARB;
            r_ptr   <= IDX_W'(rr_next(int'(r_owner), NUM_HARTS));
          end
        end
        default: r_state <= ARB;
      endcase
`else
      r_state <= ARB;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a small word memory model.
// Inputs change on the falling edge; checks sit 1 time unit after edges.
module tb_dmem_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_addr;
  logic [N-1:0]    req_ren;
  logic [N-1:0]    req_wen;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_mask;
  logic [N-1:0]    req_lock;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [31:0]     mem_addr;
  logic            mem_ren;
  logic            mem_wen;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_mask;
  logic [31:0]     mem_rdata;

  logic [31:0] mem [0:255];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_HARTS(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_ren   (req_ren),
    .i_req_wen   (req_wen),
    .i_req_wdata (req_wdata),
    .i_req_mask  (req_mask),
`ifdef DMEM_ARB_LOCK_EN
    .i_req_lock  (req_lock),
`endif
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_mem_addr  (mem_addr),
    .o_mem_ren   (mem_ren),
    .o_mem_wen   (mem_wen),
    .o_mem_wdata (mem_wdata),
    .o_mem_mask  (mem_mask),
    .i_mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b])
          mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    req_valid = '0;
    req_addr  = '0;
    req_ren   = '0;
    req_wen   = '0;
    req_wdata = '0;
    req_mask  = '0;
    req_lock  = '0;
  endtask

  task automatic put(input int h, input logic [31:0] a, input logic r,
                     input logic w, input logic [31:0] d,
                     input logic [3:0] m);
    req_valid[h]        = 1'b1;
    req_addr[h*32 +: 32] = a;
    req_ren[h]          = r;
    req_wen[h]          = w;
    req_wdata[h*32 +: 32] = d;
    req_mask[h*4 +: 4]  = m;
  endtask

  // Fall to the next negedge, leave inputs for the caller to set.
  task automatic fall();
    @(negedge clk);
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] fair_exp [0:5];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEAD_BEEF;
    clr();
    rst = 1'b1;
    put(0, 32'h0, 1'b1, 1'b0, 32'h0, 4'hF);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ren", 32'(mem_ren), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    rise();
    fall();
    rst = 1'b0;
    clr();

    // single read, hart 1, ptr 0
    put(1, 32'h102, 1'b1, 1'b0, 32'h0, 4'b1100);
    #1;
    chk("rd_ready", 32'(req_ready), 32'h2);
    chk("rd_addr", mem_addr, 32'h100);
    chk("rd_ren", 32'(mem_ren), 32'h1);
    chk("rd_mask", 32'(mem_mask), 32'hC);
    rise();
    chk("rd_vld", 32'(rsp_valid), 32'h2);
    chk("rd_data", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", 32'(rsp_err), 32'h0);

    // plain ack, hart 2, ptr 2 -> 0
    fall();
    clr();
    put(2, 32'h10, 1'b0, 1'b0, 32'h0, 4'hF);
    #1;
    chk("ack_ready", 32'(req_ready), 32'h4);
    chk("ack_mem", {30'h0, mem_ren, mem_wen}, 32'h0);
    rise();
    chk("ack_vld", 32'(rsp_valid), 32'h4);
    chk("ack_err", 32'(rsp_err), 32'h0);
    chk("ack_data", rsp_rdata, 32'h0);

    // fairness, all three requesting from ptr 0
    fall();
    clr();
    for (int h = 0; h < N; h++) put(h, 32'h40 * h, 1'b0, 1'b0, 32'h0, 4'hF);
    fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100;
    fair_exp[3] = 3'b001; fair_exp[4] = 3'b010; fair_exp[5] = 3'b100;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("fair_gnt%0d", c), 32'(req_ready), 32'(fair_exp[c]));
      rise();
      chk($sformatf("fair_vld%0d", c), 32'(rsp_valid), 32'(fair_exp[c]));
      fall();
    end

    // write by hart 2, then read by hart 0
    clr();
    put(2, 32'h200, 1'b0, 1'b1, 32'h1122_3344, 4'hF);
    #1;
    chk("wr_ready", 32'(req_ready), 32'h4);
    chk("wr_wen", 32'(mem_wen), 32'h1);
    chk("wr_wdata", mem_wdata, 32'h1122_3344);
    rise();
    chk("wr_vld", 32'(rsp_valid), 32'h4);
    chk("wr_data", rsp_rdata, 32'h0);
    fall();
    clr();
    put(0, 32'h200, 1'b1, 1'b0, 32'h0, 4'hF);
    #1;
    chk("rbk_ready", 32'(req_ready), 32'h1);
    rise();
    chk("rbk_vld", 32'(rsp_valid), 32'h1);
    chk("rbk_data", rsp_rdata, 32'h1122_3344);

    // illegal: ren+wen on hart 0 (ptr 1)
    fall();
    clr();
    put(0, 32'h200, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF);
    #1;
    chk("ill_ready", 32'(req_ready), 32'h1);
    chk("ill_mem", {30'h0, mem_ren, mem_wen}, 32'h0);
    rise();
    chk("ill_vld", 32'(rsp_valid), 32'h1);
    chk("ill_err", 32'(rsp_err), 32'h1);
    chk("ill_nowr", mem[8'h80], 32'h1122_3344);

    // illegal: zero mask store on hart 1
    fall();
    clr();
    put(1, 32'h200, 1'b0, 1'b1, 32'h0, 4'h0);
    #1;
    chk("msk_ready", 32'(req_ready), 32'h2);
    chk("msk_wen", 32'(mem_wen), 32'h0);
    rise();
    chk("msk_err", 32'(rsp_err), 32'h1);
    chk("msk_vld", 32'(rsp_valid), 32'h2);

    // idle cycle: pulse ends, rdata holds
    fall();
    clr();
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    chk("idle_addr", mem_addr, 32'h0);
    rise();
    chk("idle_vld", 32'(rsp_valid), 32'h0);
    chk("idle_err", 32'(rsp_err), 32'h0);
    chk("idle_data", rsp_rdata, 32'h0);

    // async reset mid-grant; ptr 2, hart 0 read then hart 1 write
    fall();
    clr();
    put(0, 32'h100, 1'b1, 1'b0, 32'h0, 4'hF);
    rise();
    chk("ar_pre_vld", 32'(rsp_valid), 32'h1);
    fall();
    clr();
    put(1, 32'h300, 1'b0, 1'b1, 32'hAAAA_AAAA, 4'hF);
    #1;
    chk("ar_wen_on", 32'(mem_wen), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_wen_off", 32'(mem_wen), 32'h0);
    chk("ar_ready", 32'(req_ready), 32'h0);
    chk("ar_vld", 32'(rsp_valid), 32'h0);
    chk("ar_data", rsp_rdata, 32'h0);
    rise();
    chk("ar_nowr", mem[8'hC0], 32'h0);
    fall();
    rst = 1'b0;
    clr();
    for (int h = 0; h < N; h++) put(h, 32'h0, 1'b0, 1'b0, 32'h0, 4'hF);
    #1;
    chk("ar_first", 32'(req_ready), 32'h1);
    rise();

`ifdef DMEM_ARB_LOCK_EN
    // ptr 1: hart 1 locks while 0 and 2 also request
    fall();
    req_lock = 3'b010;
    #1;
    chk("lk_g1", 32'(req_ready), 32'h2);
    rise();
    fall();
    #1;
    chk("lk_g2", 32'(req_ready), 32'h2);
    rise();
    fall();
    req_lock = 3'b000;
    #1;
    chk("lk_g3", 32'(req_ready), 32'h2);
    rise();
    fall();
    req_valid = 3'b101;
    #1;
    chk("lk_after", 32'(req_ready), 32'h4);
    rise();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
